// File: rtl/eval_latency_sm_if.sv
// Handshake bundle between a board producer/consumer and the eval latency tracker.
// busy exists only when LATENCY_SM_BUSY_EN is defined.
interface eval_latency_sm_if;
    logic board_valid;
    logic clear_eval;
    logic eval_valid;
`ifdef LATENCY_SM_BUSY_EN
    logic busy;

    modport master (
        output board_valid,
        output clear_eval,
        input  eval_valid,
        input  busy
    );

    modport slave (
        input  board_valid,
        input  clear_eval,
        output eval_valid,
        output busy
    );
`else
    modport master (
        output board_valid,
        output clear_eval,
        input  eval_valid
    );

    modport slave (
        input  board_valid,
        input  clear_eval,
        output eval_valid
    );
`endif
endinterface

// File: rtl/eval_latency_sm.sv
// Purpose: tracks when a fixed-depth evaluator's result for the latest board is ready.
// Latency: board_valid sampled at edge k -> eval_valid high after edge k+LATENCY_COUNT.
// Backpressure: none; a new board_valid restarts the countdown, clear_eval drops a held result.
// Optional feature: LATENCY_SM_BUSY_EN adds the registered busy output (high while counting).
module eval_latency_sm #(
    parameter int LATENCY_COUNT = 1
) (
    input  logic               clk,
    input  logic               reset,
    eval_latency_sm_if.slave   bus
);

    localparam int CW = (LATENCY_COUNT < 1) ? 1 : $clog2(LATENCY_COUNT + 1);
    localparam logic [CW-1:0] LOAD = CW'(LATENCY_COUNT - 1);

    generate
        if (LATENCY_COUNT < 1) begin : g_bad_latency
            $error("eval_latency_sm: LATENCY_COUNT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           run;
    logic           eval_valid_q;

    // Release stage: the FSM registers see reset drop asynchronously, but while run is
    // low their next value equals the reset value, so the first board_valid that can
    // take effect is the one sampled on the second posedge after reset rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!run) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.board_valid) begin
                        state_nxt = S_COUNT;
                        cnt_nxt   = LOAD;
                    end
                end
                S_COUNT: begin
                    if (bus.board_valid) begin
                        cnt_nxt = LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // A new board beats clear_eval: the held result is now stale.
                    if (bus.board_valid) begin
                        state_nxt = S_COUNT;
                        cnt_nxt   = LOAD;
                    end else if (bus.clear_eval) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            eval_valid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            eval_valid_q <= (state_nxt == S_DONE);
        end
    end

    assign bus.eval_valid = eval_valid_q;

`ifdef LATENCY_SM_BUSY_EN
    logic busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == S_COUNT);
        end
    end

    assign bus.busy = busy_q;
`endif

endmodule

// File: tb/tb_eval_latency_sm.sv
// Directed bench for eval_latency_sm at LATENCY_COUNT = 7, 1 and 4.
module tb_eval_latency_sm;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    eval_latency_sm_if if7();
    eval_latency_sm_if if1();
    eval_latency_sm_if if4();

    eval_latency_sm #(.LATENCY_COUNT(7)) u_l7 (.clk(clk), .reset(reset), .bus(if7));
    eval_latency_sm #(.LATENCY_COUNT(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1));
    eval_latency_sm #(.LATENCY_COUNT(4)) u_l4 (.clk(clk), .reset(reset), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Outputs are checked 1 time unit after the posedge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        if7.board_valid = 1'b0; if7.clear_eval = 1'b0;
        if1.board_valid = 1'b0; if1.clear_eval = 1'b0;
        if4.board_valid = 1'b0; if4.clear_eval = 1'b0;

        // Reset state, with a strobe present that must be ignored.
        if7.board_valid = 1'b1;
        tick();
        tick();
        if7.board_valid = 1'b0;
        chk("rst_ev7", if7.eval_valid, 1'b0);
        chk("rst_ev1", if1.eval_valid, 1'b0);
        chk("rst_ev4", if4.eval_valid, 1'b0);
`ifdef LATENCY_SM_BUSY_EN
        chk("rst_busy4", if4.busy, 1'b0);
`endif

        // Release between edges: edge 1 strobe ignored (L=1), edge 2 strobe honoured (L=4).
        #2 reset = 1'b1;
        if1.board_valid = 1'b1;
        tick();
        if1.board_valid = 1'b0;
        chk("rel_edge1_ev1", if1.eval_valid, 1'b0);
        if4.board_valid = 1'b1;
        tick();
        if4.board_valid = 1'b0;
        chk("rel_edge1_ignored_ev1", if1.eval_valid, 1'b0);
        chk("rel_edge2_ev4", if4.eval_valid, 1'b0);
`ifdef LATENCY_SM_BUSY_EN
        chk("rel_edge2_busy4", if4.busy, 1'b1);
`endif
        for (int e = 3; e <= 6; e++) begin
            tick();
            chk($sformatf("l4_edge%0d_ev", e), if4.eval_valid, (e == 6));
`ifdef LATENCY_SM_BUSY_EN
            chk($sformatf("l4_edge%0d_busy", e), if4.busy, (e < 6));
`endif
        end
        chk("rel_ev1_still0", if1.eval_valid, 1'b0);
        if4.clear_eval = 1'b1;
        tick();
        if4.clear_eval = 1'b0;
        chk("l4_clear", if4.eval_valid, 1'b0);

        // L=7 basic: strobe at edge 0, valid from edge 7, hold, then clear.
        if7.board_valid = 1'b1;
        tick();
        if7.board_valid = 1'b0;
        chk("l7_edge0", if7.eval_valid, 1'b0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("l7_edge%0d", e), if7.eval_valid, (e == 7));
        end
        tick(); tick(); tick();
        chk("l7_hold", if7.eval_valid, 1'b1);
        if7.clear_eval = 1'b1;
        tick();
        if7.clear_eval = 1'b0;
        chk("l7_cleared", if7.eval_valid, 1'b0);
        if7.clear_eval = 1'b1;
        tick();
        if7.clear_eval = 1'b0;
        chk("l7_clear_in_idle", if7.eval_valid, 1'b0);

        // Restart at edge 3 (plus ignored clear during count) -> first rise after edge 10.
        if7.board_valid = 1'b1;
        tick();
        if7.board_valid = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            if7.board_valid = (e == 3);
            if7.clear_eval  = (e == 5);
            tick();
            if7.board_valid = 1'b0;
            if7.clear_eval  = 1'b0;
            chk($sformatf("l7_restart_edge%0d", e), if7.eval_valid, (e == 10));
        end

        // board_valid and clear_eval together while valid: restart wins.
        if7.board_valid = 1'b1;
        if7.clear_eval  = 1'b1;
        tick();
        if7.board_valid = 1'b0;
        if7.clear_eval  = 1'b0;
        chk("l7_both_edge0", if7.eval_valid, 1'b0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("l7_both_edge%0d", e), if7.eval_valid, (e == 7));
        end
        if7.clear_eval = 1'b1;
        tick();
        if7.clear_eval = 1'b0;
        chk("l7_both_cleared", if7.eval_valid, 1'b0);

        // L=1: strobe every cycle for 5 cycles, valid one edge after the last.
        for (int i = 0; i < 5; i++) begin
            if1.board_valid = 1'b1;
            tick();
            chk($sformatf("l1_stream%0d", i), if1.eval_valid, 1'b0);
        end
        if1.board_valid = 1'b0;
        tick();
        chk("l1_after_last", if1.eval_valid, 1'b1);

        // Async reset mid-count on L=4, with L=1 holding a valid result.
        if4.board_valid = 1'b1;
        tick();
        if4.board_valid = 1'b0;
        tick();
        chk("pre_rst_ev1", if1.eval_valid, 1'b1);
`ifdef LATENCY_SM_BUSY_EN
        chk("pre_rst_busy4", if4.busy, 1'b1);
`endif
        #2 reset = 1'b0;
        #1;
        chk("async_rst_ev1", if1.eval_valid, 1'b0);
        chk("async_rst_ev4", if4.eval_valid, 1'b0);
`ifdef LATENCY_SM_BUSY_EN
        chk("async_rst_busy4", if4.busy, 1'b0);
`endif
        tick();
        #2 reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("post_rst_ev4_%0d", e), if4.eval_valid, 1'b0);
        end
        chk("post_rst_ev1", if1.eval_valid, 1'b0);
        chk("post_rst_ev7", if7.eval_valid, 1'b0);

        // Fresh strobe after reset completes normally.
        if4.board_valid = 1'b1;
        tick();
        if4.board_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("post_rst_new_edge%0d", e), if4.eval_valid, (e == 4));
`ifdef LATENCY_SM_BUSY_EN
            chk($sformatf("post_rst_busy_edge%0d", e), if4.busy, (e < 4));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
